// File: rtl/hdmi_feed_arbiter.sv
// hdmi_feed_arbiter: shares one sync-read pattern RAM between video and audio feeders,
// video priority with audio aging, 2-cycle tagged return.
module hdmi_feed_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24,
  parameter int AUDIO_MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  input  logic              aud_req,
  input  logic [ADDR_W-1:0] aud_addr,
  output logic              aud_gnt,
  output logic              aud_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data
);
  localparam int CW = $clog2(AUDIO_MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX = CW'(AUDIO_MAX_WAIT);
  typedef enum logic {VID_PRI, AUD_PRI} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] tag1, tag2;
  always_comb begin
    aud_gnt = !rst && aud_req && (state == AUD_PRI || !vid_req);
    vid_gnt = !rst && vid_req && !aud_gnt;
    wait_nxt = (aud_req && !aud_gnt) ? ((wait_cnt == MAX) ? MAX : wait_cnt + 1'b1) : '0;
    state_nxt = (state == VID_PRI) ? ((wait_nxt == MAX) ? AUD_PRI : VID_PRI)
                                   : ((aud_gnt || !aud_req) ? VID_PRI : AUD_PRI);
  end
  // tag bits are {video, audio}; reset empties the pipe so in-flight reads never return
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= VID_PRI;
      wait_cnt <= '0;
      en_q <= 1'b0;
      addr_q <= '0;
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      en_q <= vid_gnt || aud_gnt;
      if (vid_gnt || aud_gnt) addr_q <= aud_gnt ? aud_addr : vid_addr;
      tag1 <= {vid_gnt, aud_gnt};
      tag2 <= tag1;
    end
  end
  assign mem_en = en_q && !rst;
  assign mem_addr = rst ? '0 : addr_q;
  assign vid_rvalid = tag2[1] && !rst;
  assign aud_rvalid = tag2[0] && !rst;
  assign rd_data = mem_rdata;
endmodule

// File: tb/tb_hdmi_feed_arbiter.sv
// tb_hdmi_feed_arbiter: two arbiters (AUDIO_MAX_WAIT 8 and 1) checked every cycle against a
// refused-streak model, plus directed literal scenarios and randomized load with stray resets.
module tb_hdmi_feed_arbiter;
  localparam int AW = 16;
  localparam int DW = 24;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic vid_req[2], aud_req[2], vid_gnt[2], aud_gnt[2], vid_rvalid[2], aud_rvalid[2], mem_en[2];
  logic [AW-1:0] vid_addr[2], aud_addr[2], mem_addr[2];
  logic [DW-1:0] mem_rdata[2], rd_data[2];
  logic ex_vg[2], ex_ag[2];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 16'h0ABC) ? 24'h001234 : {a[7:0] ^ 8'hA5, a};
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL inst%0d %s cyc=%0d got=%h want=%h", g, nm, cyc, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int MW = (g == 0) ? 8 : 1;
    hdmi_feed_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUDIO_MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .vid_req(vid_req[g]), .vid_addr(vid_addr[g]), .vid_gnt(vid_gnt[g]), .vid_rvalid(vid_rvalid[g]),
      .aud_req(aud_req[g]), .aud_addr(aud_addr[g]), .aud_gnt(aud_gnt[g]), .aud_rvalid(aud_rvalid[g]),
      .mem_en(mem_en[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]), .rd_data(rd_data[g])
    );
    always @(posedge clk) if (mem_en[g]) mem_rdata[g] <= pat(mem_addr[g]);

    // model: audio earns priority after MW consecutive refused cycles; reads return two cycles after grant
    int streak = 0;
    logic p1v = 0, p1a = 0, p2v = 0, p2a = 0;
    logic [AW-1:0] p1ad = '0, p2ad = '0, last = '0;
    always @(negedge clk) begin
      logic vg, ag;
      ag = !rst && aud_req[g] && (!vid_req[g] || streak >= MW);
      vg = !rst && vid_req[g] && !ag;
      ex_vg[g] = vg;
      ex_ag[g] = ag;
      chk(g, "vid_gnt", vid_gnt[g], vg);
      chk(g, "aud_gnt", aud_gnt[g], ag);
      chk(g, "mem_en", mem_en[g], !rst && p1v);
      chk(g, "mem_addr", mem_addr[g], rst ? '0 : last);
      chk(g, "vid_rvalid", vid_rvalid[g], !rst && p2v && !p2a);
      chk(g, "aud_rvalid", aud_rvalid[g], !rst && p2v && p2a);
      if (!rst && p2v) chk(g, "rd_data", rd_data[g], pat(p2ad));
      if (rst) begin
        streak = 0;
        p1v = 0;
        p2v = 0;
        last = '0;
      end else begin
        p2v = p1v;
        p2a = p1a;
        p2ad = p1ad;
        p1v = vg || ag;
        p1a = ag;
        p1ad = ag ? aud_addr[g] : vid_addr[g];
        if (vg || ag) last = p1ad;
        streak = (aud_req[g] && !ag) ? streak + 1 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int g = 0; g < 2; g++) begin
      vid_req[g] = 0;
      aud_req[g] = 0;
    end
    repeat (n) step();
  endtask

  initial begin
    int vd, ad;
    for (int g = 0; g < 2; g++) begin
      vid_req[g] = 0; aud_req[g] = 0; vid_addr[g] = '0; aud_addr[g] = '0;
    end
    repeat (3) step();
    rst = 0;
    // video only, four back-to-back reads
    for (int k = 0; k < 8; k++) begin
      vid_req[0] = k < 4;
      vid_addr[0] = 16'(k);
      @(negedge clk);
      chk(0, "A vid_gnt", vid_gnt[0], k < 4);
      chk(0, "A mem_en", mem_en[0], k >= 1 && k < 5);
      if (k >= 1 && k < 5) chk(0, "A mem_addr", mem_addr[0], 32'(k - 1));
      chk(0, "A vid_rvalid", vid_rvalid[0], k >= 2 && k < 6);
      if (k >= 2 && k < 6) chk(0, "A rd_data", rd_data[0], pat(16'(k - 2)));
      chk(0, "A aud_rvalid", aud_rvalid[0], 0);
      step();
    end
    idle(2);
    // both requesting continuously: audio wins cycles 8 and 17
    for (int k = 0; k < 18; k++) begin
      vid_req[0] = 1; aud_req[0] = 1;
      vid_addr[0] = 16'(k); aud_addr[0] = 16'(16'h100 + k);
      @(negedge clk);
      chk(0, "B aud_gnt", aud_gnt[0], k == 8 || k == 17);
      chk(0, "B vid_gnt", vid_gnt[0], !(k == 8 || k == 17));
      step();
    end
    idle(3);
    // single audio read
    for (int k = 0; k < 4; k++) begin
      aud_req[0] = k == 0;
      aud_addr[0] = 16'h0ABC;
      @(negedge clk);
      chk(0, "C aud_gnt", aud_gnt[0], k == 0);
      chk(0, "C aud_rvalid", aud_rvalid[0], k == 2);
      if (k == 2) chk(0, "C rd_data", rd_data[0], 24'h001234);
      chk(0, "C vid_rvalid", vid_rvalid[0], 0);
      step();
    end
    idle(2);
    // audio drops after 5 refusals; counter restarts
    for (int k = 0; k < 15; k++) begin
      vid_req[0] = 1; aud_req[0] = k != 5;
      vid_addr[0] = 16'(16'h200 + k); aud_addr[0] = 16'h300;
      @(negedge clk);
      chk(0, "D aud_gnt", aud_gnt[0], k == 14);
      chk(0, "D vid_gnt", vid_gnt[0], k != 14);
      step();
    end
    idle(3);
    // reset right after a video transfer drops the read
    vid_req[0] = 1; vid_addr[0] = 16'h0055;
    @(negedge clk);
    chk(0, "E vid_gnt pre", vid_gnt[0], 1);
    step();
    rst = 1; aud_req[0] = 1;
    @(negedge clk);
    chk(0, "E vid_gnt rst", vid_gnt[0], 0);
    chk(0, "E aud_gnt rst", aud_gnt[0], 0);
    chk(0, "E mem_en rst", mem_en[0], 0);
    chk(0, "E mem_addr rst", mem_addr[0], 0);
    chk(0, "E vid_rvalid rst", vid_rvalid[0], 0);
    step();
    rst = 0;
    @(negedge clk);
    chk(0, "E vid_rvalid +1", vid_rvalid[0], 0);
    chk(0, "E vid_gnt post", vid_gnt[0], 1);
    chk(0, "E aud_gnt post", aud_gnt[0], 0);
    step();
    vid_req[0] = 0; aud_req[0] = 0;
    @(negedge clk);
    chk(0, "E vid_rvalid +2", vid_rvalid[0], 0);
    idle(3);
    // AUDIO_MAX_WAIT=1: strict alternation
    for (int k = 0; k < 10; k++) begin
      vid_req[1] = 1; aud_req[1] = 1;
      vid_addr[1] = 16'(k); aud_addr[1] = 16'(16'h400 + k);
      @(negedge clk);
      chk(1, "F vid_gnt", vid_gnt[1], k % 2 == 0);
      chk(1, "F aud_gnt", aud_gnt[1], k % 2 == 1);
      if (k >= 2) begin
        chk(1, "F vid_rvalid", vid_rvalid[1], k % 2 == 0);
        chk(1, "F aud_rvalid", aud_rvalid[1], k % 2 == 1);
      end
      step();
    end
    idle(3);
    // randomized load, requests held until granted, occasional resets
    vd = 50; ad = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) begin
        vd = $urandom_range(30, 100);
        ad = $urandom_range(10, 90);
      end
      for (int g = 0; g < 2; g++) begin
        if (!vid_req[g] || ex_vg[g]) begin
          vid_req[g] = $urandom_range(0, 99) < vd;
          vid_addr[g] = 16'($urandom);
        end
        if (!aud_req[g] || ex_ag[g]) begin
          aud_req[g] = $urandom_range(0, 99) < ad;
          aud_addr[g] = 16'($urandom);
        end
      end
      rst = $urandom_range(0, 299) == 0;
      step();
    end
    rst = 0;
    idle(4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/hdmi_feed_arbiter.md
# hdmi_feed_arbiter

Shares one single-port, synchronous-read test-pattern memory between the HDMI video feeder (24-bit pixels) and the audio feeder (16-bit samples, zero-extended in memory). It sits between the feeder sender FSMs and the pattern RAM. It arbitrates read requests with video priority plus audio aging, so audio cannot be starved, and steers returned data back to the requester with a tagged valid.

## Interface
Parameters:
- ADDR_W, 16, memory word address width
- DATA_W, 24, memory word width
- AUDIO_MAX_WAIT, 8, maximum number of consecutive cycles audio may be refused before it takes priority; legal range 1..255

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; held until accepted
- vid_addr  in  ADDR_W  video read address; stable while vid_req is high
- vid_gnt  out  1  video request accepted this cycle (combinational)
- vid_rvalid  out  1  rd_data holds video read data
- aud_req  in  1  audio read request; held until accepted
- aud_addr  in  ADDR_W  audio read address; stable while aud_req is high
- aud_gnt  out  1  audio request accepted this cycle (combinational)
- aud_rvalid  out  1  rd_data holds audio read data
- mem_en  out  1  memory read enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_rdata  in  DATA_W  memory data, valid 1 cycle after mem_en
- rd_data  out  DATA_W  shared return data bus

## Operation
- A transfer occurs in any cycle where req && gnt for one requester. At most one gnt is high per cycle, and gnt is never high without its req.
- Priority FSM, two states:
  - VID_PRI (reset state): vid_req wins. aud_gnt = aud_req && !vid_req.
  - AUD_PRI: aud_req wins. vid_gnt = vid_req && !aud_req.
- Aging counter wait_cnt is $clog2(AUDIO_MAX_WAIT+1) bits wide and saturating. Per clock edge:
  - aud_req && !aud_gnt: wait_cnt increments, saturating at AUDIO_MAX_WAIT.
  - aud_gnt, or !aud_req: wait_cnt clears to 0.
- FSM transitions:
  - VID_PRI -> AUD_PRI on the edge where wait_cnt's next value equals AUDIO_MAX_WAIT.
  - AUD_PRI -> VID_PRI on the edge of an audio transfer, or when aud_req is low.
  - There is no other way to enter AUD_PRI.
- Issue: on the edge after a transfer:
  - mem_en=1, mem_addr = accepted address.
  - 2-bit tag pipeline records the owner (video or audio) through stage 1 and stage 2.
  - With no transfer, mem_en=0 and mem_addr holds its previous value.
- Return: vid_rvalid / aud_rvalid are the stage-2 tag bits. rd_data = mem_rdata passthrough. At most one rvalid is high per cycle.
- Back-to-back transfers are allowed every cycle with no bubble. Order of returns equals order of transfers.

## Timing
- Transfer in cycle t -> mem_en/mem_addr high in cycle t+1 -> rvalid and rd_data in cycle t+2. Fixed latency of 2, no backpressure on returns.
- gnt depends only on the current req inputs and the registered FSM state. There is no comb path from mem_rdata.
- Reset behaviour:
  - All outputs reset to 0: vid_gnt, aud_gnt, vid_rvalid, aud_rvalid, mem_en, mem_addr, and rd_data qualifiers.
  - FSM resets to VID_PRI, wait_cnt to 0, tag pipeline to empty.
  - Reads in flight when rst asserts are dropped: no rvalid is produced for them.
  - gnt is forced to 0 while rst is high.
- Worst-case audio wait with video requesting every cycle: audio is refused AUDIO_MAX_WAIT cycles, then granted on the next cycle.
- AUDIO_MAX_WAIT=1: a single refused cycle flips priority, giving strict alternation under full load.
- Simultaneous requests in the cycle the FSM enters AUD_PRI: audio wins in the first AUD_PRI cycle.

## Test plan
- Video only, vid_req held 4 cycles with addr 0,1,2,3 starting at cycle 2 -> vid_gnt cycles 2-5; mem_en cycles 3-6 with mem_addr 0..3; vid_rvalid cycles 4-7 with data = mem[0..3]; aud_rvalid never high.
- Both held continuously from cycle 0, AUDIO_MAX_WAIT=8 -> vid_gnt cycles 0-7, aud_gnt cycle 8, vid_gnt cycles 9-16, aud_gnt cycle 17; wait_cnt never exceeds 8.
- Audio alone, aud_req 1 cycle with addr 0x0ABC, mem holding 0x001234 -> aud_gnt same cycle; aud_rvalid 2 cycles later with rd_data=0x001234; FSM stays VID_PRI.
- aud_req dropped at wait_cnt=5 with video busy, then reasserted -> counter restarts from 0; audio is granted only after 8 more refused cycles.
- rst asserted in the cycle after a video transfer -> no vid_rvalid in the following 2 cycles; all outputs 0 during rst; FSM in VID_PRI after release.
- AUDIO_MAX_WAIT=1, both requesting continuously -> grants alternate video/audio every cycle; rvalid tags alternate identically 2 cycles later.
